// File: rtl/robot_pkg.sv
// rtl/robot_pkg.sv - shared types and constants for the obstacle reporting path
package robot_pkg;

    localparam int         OBST_W           = 3;
    localparam logic [7:0] FRAME_HEADER_DEF = 8'hA5;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND_HDR = 2'd1,
        SEND_PAY = 2'd2
    } tx_state_t;

    typedef logic [OBST_W-1:0] obst_t;

endpackage

// File: rtl/obstacle_debounce.sv
// rtl/obstacle_debounce.sv - run-length debounce of the strobed obstacle code
//
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   obst_valid      1-cycle strobe qualifying obst
//   obst            raw obstacle code
//   obst_stable     last accepted code
//   stable_valid    sticky flag, set by the first acceptance
//   accept_change   1-cycle pulse when obst_stable takes a new (or first) value
module obstacle_debounce
    import robot_pkg::*;
#(
    parameter int STABLE_COUNT = 3
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  obst_valid,
    input  obst_t obst,
    output obst_t obst_stable,
    output logic  stable_valid,
    output logic  accept_change
);

    localparam int            RUN_W = $clog2(STABLE_COUNT + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_COUNT);
    localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

    obst_t            cand, cand_next;
    logic [RUN_W-1:0] run, run_next;

    // run saturates at STABLE_COUNT so a long steady input never wraps
    always_comb begin
        cand_next = cand;
        run_next  = run;
        if (obst_valid) begin
            if (obst == cand) begin
                run_next = (run >= RUN_MAX) ? RUN_MAX : run + 1'b1;
            end else begin
                cand_next = obst;
                run_next  = RUN_ONE;
            end
        end
    end

    // Once saturated, re-evaluating is harmless: cand already equals obst_stable.
    assign accept_change = obst_valid && (run_next == RUN_MAX) &&
                           (!stable_valid || (cand_next != obst_stable));

    always_ff @(posedge clk) begin
        if (reset) begin
            cand         <= '0;
            run          <= '0;
            obst_stable  <= '0;
            stable_valid <= 1'b0;
        end else begin
            cand <= cand_next;
            run  <= run_next;
            if (accept_change) begin
                obst_stable  <= cand_next;
                stable_valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/obstacle_reporter.sv
// rtl/obstacle_reporter.sv - frames debounced obstacle codes onto the comm-link TX handshake
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   start_comm        reporting enable; new frames start only while high
//   obst              obstacle code, sampled when ultrasonic_valid=1
//   ultrasonic_valid  1-cycle strobe qualifying obst
//   tx_ready          transmitter accepts tx_data this cycle
//   tx_valid          tx_data holds a valid byte
//   tx_data           frame byte: header, then {seq[3:0],1'b0,code[2:0]}
//   obst_stable       current debounced code
//   stable_valid      sticky, set once a first code has been accepted
module obstacle_reporter
    import robot_pkg::*;
#(
    parameter int         STABLE_COUNT     = 3,
    parameter int         HEARTBEAT_CYCLES = 5_000_000,
    parameter logic [7:0] FRAME_HEADER     = FRAME_HEADER_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_comm,
    input  obst_t      obst,
    input  logic       ultrasonic_valid,
    input  logic       tx_ready,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    output obst_t      obst_stable,
    output logic       stable_valid
);

    localparam int            HB_W    = $clog2(HEARTBEAT_CYCLES);
    localparam logic [HB_W-1:0] HB_LAST = HB_W'(HEARTBEAT_CYCLES - 1);

    tx_state_t       state, state_next;
    logic            tx_valid_next;
    logic [7:0]      tx_data_next;
    logic [7:0]      payload, payload_next;
    logic [3:0]      seq, seq_next;
    logic [HB_W-1:0] hb_cnt, hb_next;
    logic            pending, pending_next;
    logic            frame_start;
    logic            accept_change;
    logic            handshake;

    obstacle_debounce #(
        .STABLE_COUNT (STABLE_COUNT)
    ) u_debounce (
        .clk           (clk),
        .reset         (reset),
        .obst_valid    (ultrasonic_valid),
        .obst          (obst),
        .obst_stable   (obst_stable),
        .stable_valid  (stable_valid),
        .accept_change (accept_change)
    );

    assign handshake = tx_valid && tx_ready;

    always_comb begin
        state_next    = state;
        tx_valid_next = tx_valid;
        tx_data_next  = tx_data;
        payload_next  = payload;
        seq_next      = seq;
        hb_next       = hb_cnt;
        frame_start   = 1'b0;

        case (state)
            IDLE: begin
                if (start_comm && stable_valid && (pending || hb_cnt == HB_LAST)) begin
                    // payload is frozen here so later code changes cannot tear the frame
                    frame_start   = 1'b1;
                    payload_next  = {seq, 1'b0, obst_stable};
                    tx_data_next  = FRAME_HEADER;
                    tx_valid_next = 1'b1;
                    hb_next       = '0;
                    state_next    = SEND_HDR;
                end else if (start_comm) begin
                    if (hb_cnt != HB_LAST) begin
                        hb_next = hb_cnt + 1'b1;
                    end
                end else begin
                    hb_next = '0;
                end
            end
            SEND_HDR: begin
                if (handshake) begin
                    tx_data_next = payload;
                    state_next   = SEND_PAY;
                end
            end
            SEND_PAY: begin
                if (handshake) begin
                    tx_valid_next = 1'b0;
                    seq_next      = seq + 4'd1;
                    state_next    = IDLE;
                end
            end
            default: begin
                tx_valid_next = 1'b0;
                state_next    = IDLE;
            end
        endcase

        // a change accepted on the same edge a frame starts is newer than the snapshot
        pending_next = accept_change ? 1'b1 : (frame_start ? 1'b0 : pending);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            tx_valid <= 1'b0;
            tx_data  <= '0;
            payload  <= '0;
            seq      <= '0;
            hb_cnt   <= '0;
            pending  <= 1'b0;
        end else begin
            state    <= state_next;
            tx_valid <= tx_valid_next;
            tx_data  <= tx_data_next;
            payload  <= payload_next;
            seq      <= seq_next;
            hb_cnt   <= hb_next;
            pending  <= pending_next;
        end
    end

endmodule

// File: tb/tb_obstacle_reporter.sv
// tb/tb_obstacle_reporter.sv - self-checking bench for obstacle_reporter
module tb_obstacle_reporter;

    localparam int         SC  = 3;
    localparam int         HB  = 20;
    localparam logic [7:0] HDR = 8'hA5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start_comm = 1'b0;
    logic [2:0] obst = 3'd0;
    logic       ultrasonic_valid = 1'b0;
    logic       tx_ready = 1'b0;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic [2:0] obst_stable;
    logic       stable_valid;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    logic [2:0] m_hist[$];
    logic [2:0] m_stable;
    logic       m_valid;
    logic       m_pending;
    int         m_hb;
    logic [3:0] m_seq;
    int         m_byte;
    logic [7:0] m_exp_pay;
    int         frames;

    obstacle_reporter #(
        .STABLE_COUNT     (SC),
        .HEARTBEAT_CYCLES (HB),
        .FRAME_HEADER     (HDR)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .start_comm       (start_comm),
        .obst             (obst),
        .ultrasonic_valid (ultrasonic_valid),
        .tx_ready         (tx_ready),
        .tx_valid         (tx_valid),
        .tx_data          (tx_data),
        .obst_stable      (obst_stable),
        .stable_valid     (stable_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // One clock: advance the reference model with the inputs applied before the edge,
    // then check the DUT's protocol and state against it.
    task automatic tick();
        logic       tv, hs, exp_start, exp_valid, eq;
        logic [7:0] td;
        logic [2:0] old_stable;
        int         n;
        tv = tx_valid;
        td = tx_data;
        hs = tv && tx_ready;
        old_stable = m_stable;
        if (reset) begin
            @(posedge clk);
            #1;
            m_hist.delete();
            m_stable  = '0;
            m_valid   = 1'b0;
            m_pending = 1'b0;
            m_hb      = 0;
            m_seq     = '0;
            m_byte    = 0;
            return;
        end
        exp_start = !tv && start_comm && m_valid && (m_pending || m_hb == HB - 1);
        if (ultrasonic_valid) begin
            m_hist.push_back(obst);
            n = m_hist.size();
            if (n >= SC) begin
                eq = 1'b1;
                for (int i = n - SC; i < n; i++)
                    if (m_hist[i] != m_hist[n-1]) eq = 1'b0;
                if (eq && (!m_valid || m_hist[n-1] != m_stable)) begin
                    m_stable  = m_hist[n-1];
                    m_valid   = 1'b1;
                    m_pending = 1'b1;
                end else if (exp_start) begin
                    m_pending = 1'b0;
                end
            end else if (exp_start) begin
                m_pending = 1'b0;
            end
            if (m_hist.size() > 32) void'(m_hist.pop_front());
        end else if (exp_start) begin
            m_pending = 1'b0;
        end
        if (!tv) begin
            if (exp_start) m_hb = 0;
            else if (start_comm) m_hb = (m_hb < HB - 1) ? m_hb + 1 : m_hb;
            else m_hb = 0;
        end
        if (exp_start) m_exp_pay = {m_seq, 1'b0, old_stable};

        @(posedge clk);
        #1;

        exp_valid = exp_start || (tv && !(hs && m_byte == 1));
        n_cmp++;
        if (tx_valid !== exp_valid) begin
            n_err++;
            $display("FAIL tx_valid_seq: got %b expected %b at %0t", tx_valid, exp_valid, $time);
        end
        if (exp_start) begin
            n_cmp++;
            if (tx_data !== HDR) begin
                n_err++;
                $display("FAIL header_byte: got %h expected %h at %0t", tx_data, HDR, $time);
            end
        end
        if (tv && !hs) begin
            n_cmp++;
            if (tx_data !== td) begin
                n_err++;
                $display("FAIL hold_data: got %h expected %h at %0t", tx_data, td, $time);
            end
        end
        if (hs) begin
            if (m_byte == 0) begin
                n_cmp++;
                if (tx_data !== m_exp_pay) begin
                    n_err++;
                    $display("FAIL payload_byte: got %h expected %h at %0t", tx_data, m_exp_pay, $time);
                end
                m_byte = 1;
            end else begin
                m_byte = 0;
                m_seq  = m_seq + 4'd1;
                frames++;
            end
        end
        n_cmp++;
        if (obst_stable !== m_stable || stable_valid !== m_valid) begin
            n_err++;
            $display("FAIL stable_state: got %h/%b expected %h/%b at %0t",
                     obst_stable, stable_valid, m_stable, m_valid, $time);
        end
    endtask

    task automatic strobe(input logic [2:0] code, input int count);
        ultrasonic_valid = 1'b1;
        obst = code;
        for (int i = 0; i < count; i++) tick();
        ultrasonic_valid = 1'b0;
    endtask

    task automatic wait_valid(input int limit, output int n);
        n = 0;
        while (!tx_valid && n < limit) begin
            tick();
            n++;
        end
        n_cmp++;
        if (tx_valid !== 1'b1) begin
            n_err++;
            $display("FAIL wait_tx_valid: got %b after %0d cycles expected 1", tx_valid, n);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        start_comm = 1'b0;
        do_reset();
        n_cmp++;
        if (tx_valid !== 1'b0 || tx_data !== 8'h00 || obst_stable !== 3'd0 || stable_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: got %b/%h/%h/%b expected 0/00/0/0",
                     tx_valid, tx_data, obst_stable, stable_valid);
        end
    endtask

    task automatic test_first_frame();
        start_comm = 1'b1;
        tx_ready = 1'b1;
        strobe(3'b010, 3);
        n_cmp++;
        if (obst_stable !== 3'd2 || stable_valid !== 1'b1 || tx_valid !== 1'b0) begin
            n_err++;
            $display("FAIL first_accept: got %h/%b/%b expected 2/1/0", obst_stable, stable_valid, tx_valid);
        end
        tick();
        n_cmp++;
        if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin
            n_err++;
            $display("FAIL first_header: got %b/%h expected 1/a5", tx_valid, tx_data);
        end
        tick();
        n_cmp++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h02) begin
            n_err++;
            $display("FAIL first_payload: got %b/%h expected 1/02", tx_valid, tx_data);
        end
        tick();
        n_cmp++;
        if (tx_valid !== 1'b0) begin
            n_err++;
            $display("FAIL first_end: got %b expected 0", tx_valid);
        end
    endtask

    task automatic test_glitch();
        logic [2:0] seq_codes [5];
        seq_codes = '{3'd2, 3'd2, 3'd5, 3'd2, 3'd2};
        for (int i = 0; i < 8; i++) begin
            ultrasonic_valid = (i < 5);
            obst = (i < 5) ? seq_codes[i] : 3'd0;
            tick();
            n_cmp++;
            if (tx_valid !== 1'b0 || obst_stable !== 3'd2) begin
                n_err++;
                $display("FAIL glitch_ignored: got %b/%h expected 0/2 at step %0d", tx_valid, obst_stable, i);
            end
        end
        ultrasonic_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        int n;
        tx_ready = 1'b0;
        strobe(3'd6, 3);
        wait_valid(10, n);
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++;
            if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin
                n_err++;
                $display("FAIL hdr_held: got %b/%h expected 1/a5 at step %0d", tx_valid, tx_data, i);
            end
        end
        tx_ready = 1'b1;
        tick();
        n_cmp++;
        if (tx_data !== 8'h16) begin
            n_err++;
            $display("FAIL bp_payload: got %h expected 16", tx_data);
        end
        tick();
        n_cmp++;
        if (tx_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_end: got %b expected 0", tx_valid);
        end
    endtask

    task automatic test_change_during_frame();
        do_reset();
        start_comm = 1'b1;
        tx_ready = 1'b1;
        strobe(3'd2, 3);
        tick();
        tick();
        tx_ready = 1'b0;
        strobe(3'd5, 3);
        n_cmp++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h02 || obst_stable !== 3'd5) begin
            n_err++;
            $display("FAIL snapshot_kept: got %b/%h/%h expected 1/02/5", tx_valid, tx_data, obst_stable);
        end
        tx_ready = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin
            n_err++;
            $display("FAIL refresh_header: got %b/%h expected 1/a5", tx_valid, tx_data);
        end
        tick();
        n_cmp++;
        if (tx_data !== 8'h15) begin
            n_err++;
            $display("FAIL refresh_payload: got %h expected 15", tx_data);
        end
        tick();
    endtask

    task automatic test_heartbeat();
        int n;
        logic [7:0] exp;
        do_reset();
        start_comm = 1'b1;
        tx_ready = 1'b1;
        strobe(3'd3, 3);
        for (int k = 0; k < 17; k++) begin
            wait_valid(40, n);
            if (k > 0) begin
                n_cmp++;
                if (n != HB) begin
                    n_err++;
                    $display("FAIL hb_period: got %0d idle cycles expected %0d (frame %0d)", n, HB, k);
                end
            end
            tick();
            exp = {4'(k), 1'b0, 3'd3};
            n_cmp++;
            if (tx_data !== exp) begin
                n_err++;
                $display("FAIL hb_payload: got %h expected %h (frame %0d)", tx_data, exp, k);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_frame();
        int n;
        tx_ready = 1'b0;
        strobe(3'd4, 3);
        wait_valid(10, n);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++;
        if (tx_valid !== 1'b0 || tx_data !== 8'h00 || stable_valid !== 1'b0 || obst_stable !== 3'd0) begin
            n_err++;
            $display("FAIL midframe_reset: got %b/%h/%b/%h expected 0/00/0/0",
                     tx_valid, tx_data, stable_valid, obst_stable);
        end
        start_comm = 1'b0;
        tx_ready = 1'b1;
        strobe(3'd4, 3);
        for (int i = 0; i < 30; i++) begin
            tick();
            n_cmp++;
            if (tx_valid !== 1'b0) begin
                n_err++;
                $display("FAIL no_tx_disabled: got %b expected 0 at step %0d", tx_valid, i);
            end
        end
        start_comm = 1'b1;
        tick();
        n_cmp++;
        if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin
            n_err++;
            $display("FAIL enable_header: got %b/%h expected 1/a5", tx_valid, tx_data);
        end
        tick();
        n_cmp++;
        if (tx_data !== 8'h04) begin
            n_err++;
            $display("FAIL enable_payload: got %h expected 04", tx_data);
        end
        tick();
    endtask

    task automatic test_random();
        int start_frames;
        start_frames = frames;
        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(0, 999) == 0);
            if ($urandom_range(0, 29) == 0) start_comm = ~start_comm;
            ultrasonic_valid = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 4) == 0) obst = 3'($urandom_range(0, 7));
            tx_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        reset = 1'b0;
        ultrasonic_valid = 1'b0;
        n_cmp++;
        if (frames - start_frames < 20) begin
            n_err++;
            $display("FAIL random_activity: got %0d frames expected at least 20", frames - start_frames);
        end
    endtask

    initial begin
        m_stable  = '0;
        m_valid   = 1'b0;
        m_pending = 1'b0;
        m_hb      = 0;
        m_seq     = '0;
        m_byte    = 0;
        m_exp_pay = '0;
        frames    = 0;
        test_reset();
        test_first_frame();
        test_glitch();
        test_backpressure();
        test_change_during_frame();
        test_heartbeat();
        test_reset_mid_frame();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
